// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the LEGv8 fetch stage
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hb400001f;
  typedef struct packed {
    logic [63:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush, head output zeroed when empty
module fetch_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [PW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~flush;
  assign do_pop = pop & ~flush & (count != '0);
  assign dout = (count != '0) ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage (PC, imem address, fetch buffer); FETCH_HALT_EN stops fetch after HALT_INSTR
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N = 64,
  parameter int DEPTH = 2,
  parameter int AW = 6,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  output logic [AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic redirect_i,
  input  logic [N-1:0] redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [N-1:0] pc_o,
  output logic valid_o,
  input  logic ready_i,
  output logic halted_o
);
  logic [N-1:0] pc_q;
  logic [PW:0] count;
  logic halted, push, pop;
  assign imem_addr = pc_q[AW+1:2];
  assign valid_o = count != '0;
  assign pop = valid_o & ready_i;
  assign push = ~redirect_i & ~halted & ((count < (PW+1)'(DEPTH)) | pop);
  assign halted_o = halted;
  fetch_fifo #(.W(N + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_i),
    .push(push),
    .pop(pop),
    .din({pc_q, imem_q}),
    .dout({pc_o, instr_o}),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else if (redirect_i) pc_q <= {redirect_pc_i[N-1:2], 2'b00};
    else if (push) pc_q <= pc_q + N'(4);
  end
`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (!reset || redirect_i) halted <= 1'b0;
    else if (push && imem_q == HALT_INSTR) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the LEGv8 datapath. Sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the PC, drives the word address into the instruction memory and captures its combinational read data.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Branch redirects from execute flush the buffer and reload the PC.

Parameters:
- N, 64, PC / address width.
- DEPTH, 2, fetch buffer entries (power of two, ≥2).
- AW, 6, instruction-memory word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  AW  word address to instruction memory = pc_q[AW+1:2].
- imem_q  in  32  instruction-memory read data, combinational in the same cycle.
- redirect_i  in  1  branch taken/redirect request.
- redirect_pc_i  in  N  redirect target byte address.
- instr_o  out  32  instruction at buffer head.
- pc_o  out  N  PC of buffer head.
- valid_o  out  1  head entry valid.
- ready_i  in  1  decode accepts head this cycle.
- halted_o  out  1  fetch halted (see Optional Feature).

Behaviour:
- Reset:
  - Any rising edge with reset=0 sets pc_q=0 and count=0, and clears the rd/wr pointers.
  - Outputs under reset: valid_o=0, instr_o=0, pc_o=0, halted_o=0.
  - Reset asserted mid-operation discards all buffered entries in that cycle.
- Outputs:
  - instr_o and pc_o show the head entry. They are 0 when count=0.
  - valid_o = (count != 0).
- Handshake:
  - pop = valid_o & ready_i.
  - While valid_o=1 and ready_i=0, the head entry is held stable.
- Fetch:
  - push = ~redirect_i & ~halted & (count < DEPTH | pop).
  - On push, {pc_q, imem_q} is written at wr_ptr and pc_q <= pc_q + 4.
  - When the buffer is full and no pop occurs, pc_q holds and imem_addr is stable.
- Simultaneous push and pop: count unchanged. Full-and-pop allows the push.
- Redirect (highest priority after reset):
  - The buffer is flushed: count=0, pointers=0.
  - pc_q <= {redirect_pc_i[N-1:2], 2'b00}. Misaligned low bits are forced to zero.
  - The same-cycle fetch is discarded and no push occurs.
  - A same-cycle pop is still reported to decode, but the entry is lost anyway.
- Latency:
  - Out of reset: first valid_o=1 on the 2nd edge after release, with pc_o=0.
  - Redirect at edge t: target instruction valid after edge t+1.
  - Sustained throughput is 1 instruction/cycle with ready_i=1.
- Address wrap:
  - imem_addr uses pc_q[AW+1:2] only and wraps modulo 2^AW words.
  - pc_q itself is N-bit modulo-2^N.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_HALT_EN.
- With the macro defined:
  - When the instruction pushed equals HALT_INSTR (32'hb400001f, CBZ XZR,#0), the internal halted flag is set on that edge and all further pushes stop.
  - The halt instruction itself is still enqueued and delivered.
  - halted_o=1 from the next cycle.
  - Only reset or redirect_i clears halted.
- Without the macro: the halted flag is never set, halt encoding is fetched like any other, and halted_o is tied to 0.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32.
  - HALT_INSTR.
  - typedef struct packed fetch_entry_t {logic [N-1:0] pc; logic [31:0] instr}, with N fixed at 64.
- Sub-module fetch_fifo (DEPTH-entry synchronous FIFO with flush, push/pop, count):
  - Holds storage and pointers.
  - fetch_unit holds the PC, push/redirect control and halt logic.

Test Plan (bench models imem as imem_q = 32'hA000_0000 | imem_addr):
- Release reset, ready_i=1 → edge 2: valid_o=1, pc_o=0x0, instr_o=0xA0000000. Edge 3: pc_o=0x4, instr_o=0xA0000001. Continuous 1/cycle.
- ready_i=0 for 6 cycles after first valid → count saturates at 2, pc_q holds at 0x8, imem_addr=2, and head is stable at pc_o=0. With ready_i=1 restored, pc_o sequence is 0x0, 0x4, 0x8.
- redirect_i=1, redirect_pc_i=0x4A with the buffer full → next cycle valid_o=0 and imem_addr=0x12. Following cycle pc_o=0x48, instr_o=0xA0000012.
- redirect_i and pop in the same cycle, with ready_i=1 → no stale entry appears. The next delivered pc_o is the target.
- PC wraps: redirect to 0xFC → pc_o sequence 0xFC, 0x100, with imem_addr going 63 → 0 and instr_o 0xA000003F → 0xA0000000.
- (FETCH_HALT_EN) imem returns 32'hb400001f at addr 3 → halt entry is delivered with pc_o=0xC, halted_o=1, and no pc 0x10 entry. Reset asserted mid-stream → next edge valid_o=0, halted_o=0, pc_q=0.
